encoder_round_scheduler: RTL and testbench

//  Top-level sequencer for the encoder permutation datapath. Runs NUM_STAGES stage

---
 rtl/encoder_ctrl_pkg.sv | 24 ++
 rtl/ctrl_watchdog.sv | 35 +++
 rtl/encoder_round_scheduler.sv | 150 +++++++++++++++
 tb/tb_encoder_round_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_ctrl_pkg.sv
// Shared constants for the encoder round scheduler: state encoding, stage
// indices and default run geometry.
package encoder_ctrl_pkg;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
   localparam logic [ST_W-1:0] ST_ISSUE = 3'd2;
   localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
   localparam logic [ST_W-1:0] ST_WRITE = 3'd4;
   localparam logic [ST_W-1:0] ST_DONE  = 3'd5;
   localparam logic [ST_W-1:0] ST_ABORT = 3'd6;

   localparam int STG_COLPAR  = 0;
   localparam int STG_ROTATE  = 1;
   localparam int STG_PERMUTE = 2;
   localparam int STG_REVAL   = 3;
   localparam int STG_ADDRC   = 4;

   localparam int DEF_NUM_STAGES = STG_ADDRC + 1;
   localparam int DEF_NUM_ROUNDS = 24;

endpackage

// File: rtl/ctrl_watchdog.sv
// Saturating per-stage wait counter; expired flags the last permitted WAIT
// cycle. TIMEOUT of 0 disables expiry entirely.
module ctrl_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT);
   localparam logic [WW-1:0] LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : WW'(0);
   localparam bit ENABLED = (TIMEOUT != 0);

   logic [WW-1:0] count;

   // Wait-cycle counter, cleared on each stage issue and held at LIMIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= WW'(0);
      end else if (clear) begin
         count <= WW'(0);
      end else if (enable && (count != LIMIT)) begin
         count <= count + WW'(1);
      end else begin
         count <= count;
      end
   end

   assign expired = ENABLED && (count == LAST);

endmodule

// File: rtl/encoder_round_scheduler.sv
// Round/stage sequencer for the encoder permutation datapath: issues each
// stage engine in order for every round, with file load/store and a watchdog abort.
module encoder_round_scheduler
   import encoder_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
   parameter int TIMEOUT    = 1024,
   parameter int SW         = $clog2(NUM_STAGES),
   parameter int RW         = $clog2(NUM_ROUNDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic                  read_file,
   output logic                  dp_clear,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic [SW-1:0]         stage_sel,
   output logic [RW-1:0]         round_idx,
   output logic                  write_file,
   output logic                  busy,
   output logic                  finish,
   output logic                  error
);

   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

   logic [ST_W-1:0]       state;
   logic [ST_W-1:0]       state_nxt;
   logic [SW-1:0]         stage;
   logic [RW-1:0]         round;
   logic [NUM_STAGES-1:0] stage_mask;
   logic                  active_done;
   logic                  accept;
   logic                  wd_clear;
   logic                  wd_enable;
   logic                  wd_expired;
   logic                  error_flag;

   // Only the active stage's done bit can ever advance the sequence.
   assign stage_mask  = NUM_STAGES'(1) << stage;
   assign active_done = |(stage_done & stage_mask);
   assign accept      = (state == ST_WAIT) && active_done;

   assign wd_clear  = (state == ST_ISSUE);
   assign wd_enable = (state == ST_WAIT) && !active_done;

   ctrl_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Next-state decode; an accepted done takes priority over a same-cycle timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_LOAD:  state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (active_done) begin
               if ((stage == LAST_STAGE) && (round == LAST_ROUND)) begin
                  state_nxt = ST_WRITE;
               end else begin
                  state_nxt = ST_ISSUE;
               end
            end else if (wd_expired) begin
               state_nxt = ST_ABORT;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WRITE: state_nxt = ST_DONE;
         ST_ABORT: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Stage and round counters; the final accepted done leaves both at their last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage <= SW'(0);
         round <= RW'(0);
      end else if (state == ST_LOAD) begin
         stage <= SW'(0);
         round <= RW'(0);
      end else if (accept) begin
         if (stage != LAST_STAGE) begin
            stage <= stage + SW'(1);
            round <= round;
         end else if (round != LAST_ROUND) begin
            stage <= SW'(0);
            round <= round + RW'(1);
         end else begin
            stage <= stage;
            round <= round;
         end
      end else begin
         stage <= stage;
         round <= round;
      end
   end

   // Sticky abort flag, cleared when a new run loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         error_flag <= 1'b0;
      end else if (state == ST_LOAD) begin
         error_flag <= 1'b0;
      end else if (state == ST_ABORT) begin
         error_flag <= 1'b1;
      end else begin
         error_flag <= error_flag;
      end
   end

   assign read_file   = (state == ST_LOAD);
   assign dp_clear    = (state == ST_LOAD);
   assign stage_start = (state == ST_ISSUE) ? stage_mask : NUM_STAGES'(0);
   assign stage_sel   = stage;
   assign round_idx   = round;
   assign write_file  = (state == ST_WRITE);
   assign busy        = (state != ST_IDLE);
   assign finish      = (state == ST_DONE);
   assign error       = error_flag;

endmodule

// File: tb/tb_encoder_round_scheduler.sv
// Self-checking bench: a per-run latency table is expanded into an expected
// cycle-by-cycle timeline, with random noise on every input the design must ignore.
module tb_encoder_round_scheduler;

   localparam int NS   = 5;
   localparam int NR   = 24;
   localparam int TO   = 16;
   localparam int SW   = 3;
   localparam int RW   = 5;
   localparam int MAXC = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NS-1:0] stage_done;
   logic          read_file;
   logic          dp_clear;
   logic [NS-1:0] stage_start;
   logic [SW-1:0] stage_sel;
   logic [RW-1:0] round_idx;
   logic          write_file;
   logic          busy;
   logic          finish;
   logic          error;

   always #5 clk = ~clk;

   encoder_round_scheduler #(
      .NUM_STAGES (NS),
      .NUM_ROUNDS (NR),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stage_done  (stage_done),
      .read_file   (read_file),
      .dp_clear    (dp_clear),
      .stage_start (stage_start),
      .stage_sel   (stage_sel),
      .round_idx   (round_idx),
      .write_file  (write_file),
      .busy        (busy),
      .finish      (finish),
      .error       (error)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Latency table: WAIT cycle in which done arrives; 0 means the stage never finishes.
   int lat [NR][NS];
   int prev_err = 0;
   int n_cyc;
   int cut_cyc;

   int e_busy [MAXC];
   int e_read [MAXC];
   int e_write[MAXC];
   int e_fin  [MAXC];
   int e_err  [MAXC];
   int e_start[MAXC];
   int e_chk  [MAXC];
   int e_sel  [MAXC];
   int e_rnd  [MAXC];
   int d_bit  [MAXC];
   int d_val  [MAXC];

   task automatic blank(input int t);
      e_busy[t] = 1; e_read[t] = 0; e_write[t] = 0; e_fin[t] = 0; e_err[t] = 0;
      e_start[t] = 0; e_chk[t] = 0; e_sel[t] = 0; e_rnd[t] = 0; d_bit[t] = -1; d_val[t] = 0;
   endtask

   task automatic fill(input int lo, input int hi);
      for (int r = 0; r < NR; r++)
         for (int s = 0; s < NS; s++)
            lat[r][s] = $urandom_range(hi, lo);
   endtask

   task automatic active(input int t, input int r, input int s);
      blank(t);
      e_chk[t] = 1; e_sel[t] = s; e_rnd[t] = r; d_bit[t] = s;
   endtask

   task automatic build();
      int t;
      blank(0); e_busy[0] = 0; e_err[0] = prev_err;
      blank(1); e_read[1] = 1; e_err[1] = prev_err;
      t = 1;
      for (int r = 0; r < NR; r++) begin
         for (int s = 0; s < NS; s++) begin
            t++;
            blank(t);
            e_start[t] = 1 << s; e_chk[t] = 1; e_sel[t] = s; e_rnd[t] = r;
            if (r == 10 && s == 2) cut_cyc = t + 1;
            if (lat[r][s] > 0) begin
               for (int j = 1; j <= lat[r][s]; j++) begin
                  t++;
                  active(t, r, s);
                  d_val[t] = (j == lat[r][s]) ? 1 : 0;
               end
            end else begin
               for (int j = 1; j <= TO; j++) begin
                  t++;
                  active(t, r, s);
               end
               t++;
               blank(t); e_chk[t] = 1; e_sel[t] = s; e_rnd[t] = r;
               t++;
               blank(t); e_fin[t] = 1; e_err[t] = 1;
               n_cyc = t + 1;
               prev_err = 1;
               return;
            end
         end
      end
      t++; blank(t); e_write[t] = 1;
      t++; blank(t); e_fin[t] = 1;
      n_cyc = t + 1;
      prev_err = 0;
   endtask

   task automatic run(input bit hold, input int stop_at);
      for (int t = 0; t < n_cyc; t++) begin
         if (stop_at >= 0 && t == stop_at) return;
         start = (t == 0 || hold) ? 1'b1 : 1'($urandom_range(1, 0));
         for (int b = 0; b < NS; b++)
            stage_done[b] = (b == d_bit[t]) ? (d_val[t] != 0) : 1'($urandom_range(1, 0));
         @(negedge clk);
         check($sformatf("busy@%0d", t), 32'(busy), e_busy[t]);
         check($sformatf("read_file@%0d", t), 32'(read_file), e_read[t]);
         check($sformatf("dp_clear@%0d", t), 32'(dp_clear), e_read[t]);
         check($sformatf("write_file@%0d", t), 32'(write_file), e_write[t]);
         check($sformatf("finish@%0d", t), 32'(finish), e_fin[t]);
         check($sformatf("error@%0d", t), 32'(error), e_err[t]);
         check($sformatf("stage_start@%0d", t), 32'(stage_start), e_start[t]);
         if (e_chk[t] != 0) begin
            check($sformatf("stage_sel@%0d", t), 32'(stage_sel), e_sel[t]);
            check($sformatf("round_idx@%0d", t), 32'(round_idx), e_rnd[t]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         stage_done = NS'($urandom_range(31, 0));
         @(negedge clk);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_finish", 32'(finish), 32'd0);
         check("idle_read", 32'(read_file), 32'd0);
         check("idle_start", 32'(stage_start), 32'd0);
         check("idle_error", 32'(error), 32'(prev_err));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_read"}, 32'(read_file), 32'd0);
      check({tag, "_clear"}, 32'(dp_clear), 32'd0);
      check({tag, "_write"}, 32'(write_file), 32'd0);
      check({tag, "_finish"}, 32'(finish), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_start"}, 32'(stage_start), 32'd0);
      check({tag, "_sel"}, 32'(stage_sel), 32'd0);
      check({tag, "_round"}, 32'(round_idx), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      stage_done = '0;
      #12;
      reset_outputs("por");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(2);

      // Nominal run: every stage done in its first WAIT cycle.
      fill(1, 1); build(); run(1'b0, -1); idle(2);

      // Stage 3 takes 7 WAIT cycles in every round.
      fill(1, 1);
      for (int r = 0; r < NR; r++) lat[r][3] = 7;
      build(); run(1'b0, -1); idle(2);

      // Stage 2 of round 5 hangs: watchdog abort, error stays set while idle.
      fill(1, 1); lat[5][2] = 0; build(); run(1'b0, -1); idle(3);

      // Random latencies, including done on the very cycle the watchdog would fire.
      fill(1, TO); lat[0][0] = TO; lat[23][4] = TO; build(); run(1'b0, -1); idle(2);

      // Reset asserted during a WAIT of round 10, then a clean run.
      fill(1, 4); build(); run(1'b0, cut_cyc);
      rst = 1'b0;
      #1;
      reset_outputs("midrst");
      prev_err = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(1);
      fill(1, 1); build(); run(1'b0, -1); idle(1);

      // start held high: the next run begins in the IDLE cycle right after finish.
      fill(1, 1); build(); run(1'b1, -1);
      fill(1, 3); build(); run(1'b0, -1); idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
